// File: rtl/ram_single_be.sv
`default_nettype none
// ============================================================================
// Module   : ram_single_be
// Brief    : Single-port RAM with byte-lane write enables, selectable
//            read-during-write mode and an optional output register stage.
//            Defining RAM_CLEAR_EN adds a post-reset zero-fill sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module ram_single_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data,
    output logic [DATA_WIDTH-1:0]          q,
    output logic                           q_valid,
    output logic                           ready
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_ready_q;
    logic [DATA_WIDTH-1:0] r_rd_data_q;
    logic                  r_rd_valid_q;

    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd_data_d;
    logic                  w_rd_valid_d;

    // rst gates acceptance directly so a request in the first reset cycle is dropped
    always_comb begin
        w_acc    = en && r_ready_q && !rst;
        w_wr     = w_acc && we && (|be);
        w_rd     = w_acc && !((RDW_MODE == 2) && we && (|be));
        w_old    = r_mem[addr];
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        w_rd_data_d  = r_rd_data_q;
        w_rd_valid_d = 1'b0;
        if (w_rd) begin
            w_rd_data_d  = ((RDW_MODE == 1) && we) ? w_merged : w_old;
            w_rd_valid_d = 1'b1;
        end
    end

`ifdef RAM_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                r_state_q;
    logic [ADDR_WIDTH-1:0] r_clr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_CLEAR;
            r_clr_cnt_q <= '0;
            r_ready_q   <= 1'b0;
        end else begin
            case (r_state_q)
                ST_CLEAR: begin
                    r_clr_cnt_q <= r_clr_cnt_q + 1'b1;
                    if (r_clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        r_state_q <= ST_IDLE;
                        r_ready_q <= 1'b1;
                    end
                end
                default: begin
                    r_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (r_state_q == ST_CLEAR)) begin
            r_mem[r_clr_cnt_q] <= '0;
        end else if (w_wr) begin
            r_mem[addr] <= w_merged;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_q <= 1'b0;
        end else begin
            r_ready_q <= 1'b1;
        end
    end

    // Memory contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[addr] <= w_merged;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_q  <= '0;
            r_rd_valid_q <= 1'b0;
        end else begin
            r_rd_data_q  <= w_rd_data_d;
            r_rd_valid_q <= w_rd_valid_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q2_q;
            logic [DATA_WIDTH-1:0] w_q2_d;
            logic                  r_v2_q;

            always_comb begin
                w_q2_d = r_rd_valid_q ? r_rd_data_q : r_q2_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q2_q <= '0;
                    r_v2_q <= 1'b0;
                end else begin
                    r_q2_q <= w_q2_d;
                    r_v2_q <= r_rd_valid_q;
                end
            end

            assign q       = r_q2_q;
            assign q_valid = r_v2_q;
        end else begin : g_no_out_reg
            assign q       = r_rd_data_q;
            assign q_valid = r_rd_valid_q;
        end
    endgenerate

    assign ready = r_ready_q;

endmodule
`default_nettype wire

// File: doc/ram_single_be.md
RAM_SINGLE_BE -- requirements
Module: ram_single_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the data word in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: bits per byte lane; NB = DATA_WIDTH/BYTE_WIDTH lanes.
REQ-004 SHALL have parameter RDW_MODE, default 0: read-during-write behaviour; 0 = read-first, 1 = write-first, 2 = no-change.
REQ-005 SHALL have parameter OUT_REG, default 0: 1 adds an output pipeline register stage.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-008 SHALL have port en, input, 1 bit: access request for this cycle.
REQ-009 SHALL have port we, input, 1 bit: write enable; qualified by en.
REQ-010 SHALL have port be, input, NB bits: byte-lane write enables; bit i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-011 SHALL have port addr, input, ADDR_WIDTH bits: access address.
REQ-012 SHALL have port data, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port q, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port q_valid, output, 1 bit: one-cycle pulse marking q as carrying new read data.
REQ-015 SHALL have port ready, output, 1 bit: block accepts requests.

Function
REQ-016 SHALL accept an access only in a cycle with en=1 and ready=1; all other requests are ignored and have no side effect.
REQ-017 SHALL, on an accepted access with we=1, update only the lanes with be[i]=1 at addr; lanes with be[i]=0 keep their contents.
REQ-018 SHALL treat every accepted access (we=0 or we=1) as a read of addr, except under RDW_MODE=2 with we=1.
REQ-019 SHALL present read data on q with q_valid=1 exactly 1 cycle after acceptance when OUT_REG=0 and 2 cycles after when OUT_REG=1.
REQ-020 SHALL, for a read coinciding with a write to the same address: RDW_MODE=0 return the old word; RDW_MODE=1 return the merged new word (written lanes new, others old); RDW_MODE=2 keep q unchanged and not assert q_valid.
REQ-021 SHALL hold q at its last value in cycles where q_valid=0.
REQ-022 SHALL sustain one accepted access per cycle, back-to-back, at full throughput in both OUT_REG settings.
REQ-023 SHALL treat be=0 with we=1 as a read under every RDW_MODE, with no memory change.
REQ-024 SHALL require DATA_WIDTH to be an integer multiple of BYTE_WIDTH; other values are unsupported.

Reset
REQ-025 SHALL, while rst=1, drive q=0, q_valid=0, ready=0, and discard any in-flight pipeline read.
REQ-026 SHALL ignore en, we and be while rst=1.
REQ-027 SHALL, without RAM_CLEAR_EN, drive ready=1 from the first cycle after rst deasserts; memory contents are not altered by reset.

Configuration
REQ-028 SHALL compile in a post-reset clear sequencer only when macro RAM_CLEAR_EN is defined.
REQ-029 SHALL, with RAM_CLEAR_EN, use FSM states CLEAR and IDLE: rst forces CLEAR with clear counter 0; CLEAR writes all-zero to address counter, one address per cycle, counter incrementing; after address DEPTH-1 transition to IDLE; IDLE sets ready=1 and persists until rst.
REQ-030 SHALL, with RAM_CLEAR_EN, assert ready first exactly DEPTH cycles after the first cycle with rst=0, and keep ready=0 and q_valid=0 throughout CLEAR.
REQ-031 SHALL, with RAM_CLEAR_EN, restart the clear from address 0 when rst asserts mid-CLEAR.
REQ-032 SHALL, without RAM_CLEAR_EN, contain no FSM and no clear counter.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4, BYTE_WIDTH=8)
REQ-033 SHALL cover: write 0xDEADBEEF to addr 3 with be=4'hF, read addr 3 -> q=0xDEADBEEF with q_valid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-034 SHALL cover: with addr 3 = 0xDEADBEEF, write 0x11223344 with be=4'b0101 -> subsequent read of addr 3 gives 0xDE22BE44.
REQ-035 SHALL cover: addr 5 = 0xAAAAAAAA, same-cycle write 0x55555555 be=4'hF -> q=0xAAAAAAAA (RDW_MODE=0), 0x55555555 (RDW_MODE=1), q unchanged with q_valid=0 (RDW_MODE=2).
REQ-036 SHALL cover: RAM_CLEAR_EN defined, preload nonzero, pulse rst -> ready low 16 cycles, requests ignored, then reads of addr 0..15 all return 0.
REQ-037 SHALL cover: RAM_CLEAR_EN defined, rst reasserted at clear address 7 -> ready reasserts 16 cycles after the second deassert.
REQ-038 SHALL cover: 16 back-to-back reads of addr 0..15 -> 16 consecutive q_valid pulses, data in address order, no bubbles.
